// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI burst scheduler.
//   sched_state_e : scheduler FSM states
//   BURST_INCR    : AXI INCR burst encoding
//   RESP_OKAY     : AXI OKAY response encoding
//   PAGE_BYTES    : 4 KB boundary that no burst may cross
//   min16()       : unsigned minimum helper for beat counts
package axi_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_e;

    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [12:0] PAGE_BYTES = 13'd4096;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_sched_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, resetn : clock, async active-low reset
//   req_i       : request vector
//   accept_i    : grant is taken this cycle; updates the last-granted pointer
//   grant_o     : one-hot grant (zero when nobody requests)
//   gidx_o      : index of the granted requester
// The pointer holds the last granted requester and resets to 1, so
// requester 0 wins the first tie.
module axi_sched_rr_arbiter (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o,
    output logic       gidx_o
);

    logic last_q;
    logic last_d;

    // Pick the requester not granted last on a tie, otherwise the only one asking.
    always_comb begin
        gidx_o = 1'b0;
        case (req_i)
            2'b01:   gidx_o = 1'b0;
            2'b10:   gidx_o = 1'b1;
            2'b11:   gidx_o = ~last_q;
            default: gidx_o = 1'b0;
        endcase
        if (req_i != 2'b00) begin
            grant_o = gidx_o ? 2'b10 : 2'b01;
        end else begin
            grant_o = 2'b00;
        end
        if (accept_i) begin
            last_d = gidx_o;
        end else begin
            last_d = last_q;
        end
    end

    // Last-granted pointer register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_burst_scheduler.sv
// Shares one AXI burst master between two requesters and splits each
// transfer into INCR bursts of at most MAX_BEATS that never cross 4 KB.
//   clk, resetn                 : clock, async active-low reset
//   req_valid/write/addr/beats  : per-requester transfer request
//   req_ready/done/err          : accept strobe, completion pulse, error flag
//   start_*/ *_id/addr/len/size/burst : burst launch controls to the master
//   wr_/rd_burst_done/resp      : per-burst completion from B / R channels
module axi_burst_scheduler
    import axi_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int BEAT_BYTES = 4,
    parameter int MAX_BEATS  = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_write,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][15:0]           req_beats,
    output logic [1:0]                 req_ready,
    output logic [1:0]                 req_done,
    output logic [1:0]                 req_err,
    output logic                       start_write,
    output logic                       start_read,
    output logic [ID_WIDTH-1:0]        write_id,
    output logic [ID_WIDTH-1:0]        read_id,
    output logic [ADDR_WIDTH-1:0]      write_addr,
    output logic [ADDR_WIDTH-1:0]      read_addr,
    output logic [31:0]                write_len,
    output logic [31:0]                read_len,
    output logic [2:0]                 write_size,
    output logic [2:0]                 read_size,
    output logic [1:0]                 write_burst,
    output logic [1:0]                 read_burst,
    input  logic                       wr_burst_done,
    input  logic [1:0]                 wr_burst_resp,
    input  logic                       rd_burst_done,
    input  logic [1:0]                 rd_burst_resp
);

    localparam int                    BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [15:0]           MAX_LEN    = 16'(MAX_BEATS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BEAT_BYTES - 1));

    sched_state_e          state_q, state_d;
    logic                  dir_q, dir_d;        // 1 = write
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           rem_q, rem_d;
    logic [15:0]           len_q, len_d;
    logic                  owner_q, owner_d;
    logic                  err_q, err_d;
    logic                  start_wr_q, start_wr_d, start_rd_q, start_rd_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [31:0]           wlen_q, wlen_d, rlen_q, rlen_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d, rid_q, rid_d;
    logic [1:0]            done_q, done_d, rerr_q, rerr_d;

    logic [1:0]            grant_s;
    logic                  gidx_s;
    logic                  accept_s;
    logic [15:0]           page_left_s;
    logic [15:0]           calc_len_s;
    logic                  burst_done_s;
    logic [1:0]            burst_resp_s;
    logic [15:0]           rem_after_s;
    logic                  err_next_s;

    assign accept_s = (state_q == ST_IDLE) && (req_valid != 2'b00);

    axi_sched_rr_arbiter u_arb (
        .clk      (clk),
        .resetn   (resetn),
        .req_i    (req_valid),
        .accept_i (accept_s),
        .grant_o  (grant_s),
        .gidx_o   (gidx_s)
    );

    // Burst sizing and completion decode shared by next-state and output logic.
    always_comb begin
        // Beats left before the next 4 KB boundary; addr_q is beat aligned.
        page_left_s  = 16'((PAGE_BYTES - {1'b0, addr_q[11:0]}) >> BEAT_SHIFT);
        calc_len_s   = min16(min16(rem_q, MAX_LEN), page_left_s);
        burst_done_s = dir_q ? wr_burst_done : rd_burst_done;
        burst_resp_s = dir_q ? wr_burst_resp : rd_burst_resp;
        rem_after_s  = rem_q - len_q;
        err_next_s   = err_q | (burst_resp_s != RESP_OKAY);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (req_beats[gidx_s] != 16'd0)) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC:  state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (burst_done_s && (rem_after_s == 16'd0)) begin
                    state_d = ST_IDLE;
                end else if (burst_done_s) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output / datapath next values.
    always_comb begin
        dir_d      = dir_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        owner_d    = owner_q;
        err_d      = err_q;
        start_wr_d = 1'b0;
        start_rd_d = 1'b0;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        wlen_d     = wlen_q;
        rlen_d     = rlen_q;
        wid_d      = wid_q;
        rid_d      = rid_q;
        done_d     = 2'b00;
        rerr_d     = 2'b00;
        req_ready  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                req_ready = grant_s;
                if (accept_s) begin
                    dir_d   = req_write[gidx_s];
                    addr_d  = req_addr[gidx_s] & ALIGN_MASK;
                    rem_d   = req_beats[gidx_s];
                    owner_d = gidx_s;
                    err_d   = 1'b0;
                    // Empty transfer completes without touching the bus.
                    if (req_beats[gidx_s] == 16'd0) begin
                        done_d[gidx_s] = 1'b1;
                    end else begin
                        done_d = 2'b00;
                    end
                end else begin
                    err_d = err_q;
                end
            end
            ST_CALC: begin
                len_d = calc_len_s;
                // Launch pulse lands in ISSUE together with the new controls.
                if (dir_q) begin
                    start_wr_d = 1'b1;
                    waddr_d    = addr_q;
                    wlen_d     = 32'(calc_len_s) - 32'd1;
                    wid_d      = ID_WIDTH'(owner_q);
                end else begin
                    start_rd_d = 1'b1;
                    raddr_d    = addr_q;
                    rlen_d     = 32'(calc_len_s) - 32'd1;
                    rid_d      = ID_WIDTH'(owner_q);
                end
            end
            ST_ISSUE: begin
                err_d = err_q;
            end
            ST_WAIT: begin
                if (burst_done_s) begin
                    err_d  = err_next_s;
                    addr_d = addr_q + (ADDR_WIDTH'(len_q) << BEAT_SHIFT);
                    rem_d  = rem_after_s;
                    if (rem_after_s == 16'd0) begin
                        done_d[owner_q] = 1'b1;
                        rerr_d[owner_q] = err_next_s;
                    end else begin
                        done_d = 2'b00;
                    end
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                err_d = err_q;
            end
        endcase
    end

    // Datapath and registered output state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q      <= 1'b0;
            addr_q     <= '0;
            rem_q      <= 16'd0;
            len_q      <= 16'd0;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
            start_wr_q <= 1'b0;
            start_rd_q <= 1'b0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wlen_q     <= 32'd0;
            rlen_q     <= 32'd0;
            wid_q      <= '0;
            rid_q      <= '0;
            done_q     <= 2'b00;
            rerr_q     <= 2'b00;
        end else begin
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
            start_wr_q <= start_wr_d;
            start_rd_q <= start_rd_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            wlen_q     <= wlen_d;
            rlen_q     <= rlen_d;
            wid_q      <= wid_d;
            rid_q      <= rid_d;
            done_q     <= done_d;
            rerr_q     <= rerr_d;
        end
    end

    assign req_done    = done_q;
    assign req_err     = rerr_q;
    assign start_write = start_wr_q;
    assign start_read  = start_rd_q;
    assign write_addr  = waddr_q;
    assign read_addr   = raddr_q;
    assign write_len   = wlen_q;
    assign read_len    = rlen_q;
    assign write_id    = wid_q;
    assign read_id     = rid_q;
    assign write_size  = 3'(BEAT_SHIFT);
    assign read_size   = 3'(BEAT_SHIFT);
    assign write_burst = BURST_INCR;
    assign read_burst  = BURST_INCR;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
module tb_axi_burst_scheduler;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_write = 2'b00;
    logic [1:0][31:0]  req_addr = '0;
    logic [1:0][15:0]  req_beats = '0;
    logic [1:0]        req_ready, req_done, req_err;
    logic              start_write, start_read;
    logic [3:0]        write_id, read_id;
    logic [31:0]       write_addr, read_addr, write_len, read_len;
    logic [2:0]        write_size, read_size;
    logic [1:0]        write_burst, read_burst;
    logic              wr_burst_done = 1'b0, rd_burst_done = 1'b0;
    logic [1:0]        wr_burst_resp = 2'b00, rd_burst_resp = 2'b00;

    int checks = 0;
    int errors = 0;
    int tb_last = 1;   // reference round-robin pointer: last granted requester

    // observed bursts of the current transfer
    logic [31:0] obs_addr[$];
    logic [31:0] obs_len[$];
    logic [3:0]  obs_id[$];
    bit          obs_wr[$];
    logic [1:0]  obs_resp[$];
    // reference bursts
    logic [31:0] exp_addr[$];
    int          exp_len[$];
    bit t_done, t_err, t_timeout, t_timing_bad, t_ready_bad, t_other_done;
    int t_done_cyc;

    always #5 clk = ~clk;

    axi_burst_scheduler dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_beats(req_beats),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .start_write(start_write), .start_read(start_read),
        .write_id(write_id), .read_id(read_id),
        .write_addr(write_addr), .read_addr(read_addr),
        .write_len(write_len), .read_len(read_len),
        .write_size(write_size), .read_size(read_size),
        .write_burst(write_burst), .read_burst(read_burst),
        .wr_burst_done(wr_burst_done), .wr_burst_resp(wr_burst_resp),
        .rd_burst_done(rd_burst_done), .rd_burst_resp(rd_burst_resp)
    );

    // Reference split: min(remaining, 16, beats left in the 4 KB page), 4-byte beats.
    function automatic void model_bursts(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int rem, len, room;
        exp_addr.delete();
        exp_len.delete();
        a = addr & ~32'd3;
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a % 32'd4096)) / 4;
            len = rem;
            if (len > 16) len = 16;
            if (len > room) len = room;
            exp_addr.push_back(a);
            exp_len.push_back(len);
            a = a + 32'(len * 4);
            rem -= len;
        end
    endfunction

    // Drive one transfer for requester r and act as the AXI master; records what happened.
    task automatic do_transfer(input int r, input bit wr, input logic [31:0] addr, input logic [15:0] beats,
                               input logic [1:0] first_resp, input bit rand_resp, input bit noise);
        int last_done_iter = -1;
        bit pending = 0;
        int delay = 0;
        int nstart = 0;
        logic [1:0] resp;
        obs_addr.delete(); obs_len.delete(); obs_id.delete(); obs_wr.delete(); obs_resp.delete();
        t_done = 0; t_err = 0; t_timeout = 0; t_timing_bad = 0; t_ready_bad = 0; t_other_done = 0;
        t_done_cyc = -2;
        req_write[r] = wr; req_addr[r] = addr; req_beats[r] = beats; req_valid[r] = 1'b1;
        #1;
        if (req_ready !== (2'b01 << r)) t_ready_bad = 1;
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        tb_last = r;
        #1;
        if (req_ready !== 2'b00) t_ready_bad = 1;
        if (req_done[1-r]) t_other_done = 1;
        if (req_done[r]) begin t_done = 1; t_err = req_err[r]; t_done_cyc = -1; end
        for (int cyc = 0; cyc < 600 && !t_done; cyc++) begin
            @(posedge clk); #1;
            wr_burst_done = 1'b0; rd_burst_done = 1'b0; wr_burst_resp = 2'b00; rd_burst_resp = 2'b00;
            if (req_done[1-r]) t_other_done = 1;
            if (req_done[r]) begin
                t_done = 1; t_err = req_err[r]; t_done_cyc = cyc;
                if (cyc != last_done_iter + 1) t_timing_bad = 1;
            end else if (start_write || start_read) begin
                if (start_write && start_read) t_timing_bad = 1;
                if (nstart == 0 ? (cyc != 0) : (cyc != last_done_iter + 2)) t_timing_bad = 1;
                obs_wr.push_back(start_write);
                obs_addr.push_back(start_write ? write_addr : read_addr);
                obs_len.push_back(start_write ? write_len : read_len);
                obs_id.push_back(start_write ? write_id : read_id);
                pending = 1; delay = $urandom_range(0, 2); nstart++;
                // completion seen while still in ISSUE must be ignored
                if (noise) begin
                    if (wr) begin wr_burst_done = 1'b1; wr_burst_resp = 2'b10; end
                    else begin rd_burst_done = 1'b1; rd_burst_resp = 2'b10; end
                end
            end else if (pending) begin
                if (delay == 0) begin
                    if (obs_resp.size() == 0) resp = first_resp;
                    else if (rand_resp && $urandom_range(0, 7) == 0) resp = 2'($urandom_range(1, 3));
                    else resp = 2'b00;
                    obs_resp.push_back(resp);
                    if (wr) begin wr_burst_done = 1'b1; wr_burst_resp = resp; end
                    else begin rd_burst_done = 1'b1; rd_burst_resp = resp; end
                    pending = 0; last_done_iter = cyc;
                end else begin
                    delay--;
                    // completion of the other direction must be ignored
                    if (noise) begin
                        if (wr) begin rd_burst_done = 1'b1; rd_burst_resp = 2'b10; end
                        else begin wr_burst_done = 1'b1; wr_burst_resp = 2'b10; end
                    end
                end
            end
        end
        if (!t_done) t_timeout = 1;
        wr_burst_done = 1'b0; rd_burst_done = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, req_done, req_err, start_write, start_read} !== 8'd0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {req_ready, req_done, req_err, start_write, start_read});
        end
        checks++;
        if ({write_addr, read_addr, write_len, read_len, write_id, read_id} !== '0) begin
            errors++; $display("FAIL reset_regs waddr %h raddr %h wlen %0d rlen %0d want 0", write_addr, read_addr, write_len, read_len);
        end
        checks++;
        if ({write_size, read_size, write_burst, read_burst} !== {3'd2, 3'd2, 2'b01, 2'b01}) begin
            errors++; $display("FAIL reset_const size %0d/%0d burst %b/%b want 2/2 01/01", write_size, read_size, write_burst, read_burst);
        end
        resetn = 1'b1;
        tb_last = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_rr;
        logic [1:0] want;
        int g;
        req_beats = '0; req_write = 2'b00;
        for (int round = 0; round < 2; round++) begin
            req_valid = 2'b11;
            for (int k = 0; k < 2; k++) begin
                #1;
                g = (req_valid == 2'b11) ? 1 - tb_last : (req_valid[1] ? 1 : 0);
                want = 2'b01 << g;
                checks++;
                if (req_ready !== want) begin
                    errors++; $display("FAIL rr_grant round %0d got %b want %b", round, req_ready, want);
                end
                @(posedge clk); #1;
                req_valid[g] = 1'b0;
                tb_last = g;
                checks++;
                if (req_done !== want) begin
                    errors++; $display("FAIL rr_done round %0d got %b want %b", round, req_done, want);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_split_rules;
        int          t_r   [6] = '{0, 1, 0, 1, 0, 1};
        bit          t_wr  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_addr[6] = '{32'h0000_1000, 32'h0000_0000, 32'h0000_0FF8, 32'hFFFF_FFF0, 32'h0000_0103, 32'h0000_2000};
        int          t_bt  [6] = '{8, 40, 4, 8, 3, 0};
        for (int n = 0; n < 6; n++) begin
            do_transfer(t_r[n], t_wr[n], t_addr[n], 16'(t_bt[n]), 2'b00, 1'b0, 1'b0);
            model_bursts(t_addr[n], t_bt[n]);
            checks++;
            if (obs_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL split_count case %0d got %0d want %0d", n, obs_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    checks++;
                    if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== 32'(exp_len[i] - 1) ||
                        obs_wr[i] !== t_wr[n] || obs_id[i] !== 4'(t_r[n])) begin
                        errors++;
                        $display("FAIL split_burst case %0d #%0d got addr %h len %0d wr %0d id %0d want addr %h len %0d wr %0d id %0d",
                                 n, i, obs_addr[i], obs_len[i], obs_wr[i], obs_id[i], exp_addr[i], exp_len[i] - 1, t_wr[n], t_r[n]);
                    end
                end
            end
            checks++;
            if (!t_done || t_err !== 1'b0 || t_timing_bad || t_ready_bad || t_other_done) begin
                errors++; $display("FAIL split_done case %0d got done %0d err %0d timing %0d ready %0d other %0d want 1 0 0 0 0",
                                   n, t_done, t_err, t_timing_bad, t_ready_bad, t_other_done);
            end
        end
        checks++;
        if ({write_size, read_size, write_burst, read_burst} !== {3'd2, 3'd2, 2'b01, 2'b01}) begin
            errors++; $display("FAIL const_ctrl size %0d/%0d burst %b/%b want 2/2 01/01", write_size, read_size, write_burst, read_burst);
        end
    endtask

    task automatic test_error;
        do_transfer(0, 1'b0, 32'h0000_0200, 16'd32, 2'b10, 1'b0, 1'b0);
        checks++;
        if (obs_addr.size() != 2) begin
            errors++; $display("FAIL err_bursts got %0d want 2", obs_addr.size());
        end
        checks++;
        if (!t_done || t_err !== 1'b1) begin
            errors++; $display("FAIL err_flag got done %0d err %0d want 1 1", t_done, t_err);
        end
    endtask

    task automatic test_random;
        int r, beats, mode;
        bit wr, exp_err;
        logic [31:0] addr;
        logic [1:0] fr;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            addr = $urandom;
            if (mode == 1) addr = {addr[31:12], 4'hF, addr[7:0]};
            if (mode == 2) addr = {24'hFFFFFF, addr[7:0]};
            beats = $urandom_range(0, 70);
            fr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_transfer(r, wr, addr, 16'(beats), fr, 1'b1, 1'b1);
            model_bursts(addr, beats);
            exp_err = 0;
            foreach (obs_resp[i]) if (obs_resp[i] != 2'b00) exp_err = 1;
            checks++;
            if (obs_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL rand_count #%0d addr %h beats %0d got %0d want %0d", n, addr, beats, obs_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    checks++;
                    if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== 32'(exp_len[i] - 1) ||
                        obs_wr[i] !== wr || obs_id[i] !== 4'(r)) begin
                        errors++;
                        $display("FAIL rand_burst #%0d.%0d got addr %h len %0d wr %0d id %0d want addr %h len %0d wr %0d id %0d",
                                 n, i, obs_addr[i], obs_len[i], obs_wr[i], obs_id[i], exp_addr[i], exp_len[i] - 1, wr, r);
                    end
                end
            end
            checks++;
            if (!t_done || t_err !== exp_err || t_timing_bad || t_ready_bad || t_other_done) begin
                errors++; $display("FAIL rand_done #%0d got done %0d err %0d timing %0d ready %0d other %0d want 1 %0d 0 0 0",
                                   n, t_done, t_err, t_timing_bad, t_ready_bad, t_other_done, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen_start = 0;
        bit seen_done = 0;
        req_write[1] = 1'b0; req_addr[1] = 32'h0000_3000; req_beats[1] = 16'd32; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        for (int c = 0; c < 10 && !seen_start; c++) begin
            @(posedge clk); #1;
            if (start_read) seen_start = 1;
        end
        checks++;
        if (!seen_start) begin
            errors++; $display("FAIL rstmid_start got 0 want 1");
        end
        @(posedge clk); #1;     // now waiting for the burst completion
        resetn = 1'b0;
        #1;
        checks++;
        if ({req_done, req_err, start_write, start_read, read_addr, read_len, read_id} !== '0 ||
            {read_size, read_burst} !== {3'd2, 2'b01}) begin
            errors++; $display("FAIL rstmid_outputs got done %b raddr %h rlen %0d rid %0d want 0", req_done, read_addr, read_len, read_id);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (req_done !== 2'b00) seen_done = 1;
        end
        resetn = 1'b1;
        tb_last = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (req_done !== 2'b00 || start_read || start_write) seen_done = 1;
        end
        checks++;
        if (seen_done) begin
            errors++; $display("FAIL rstmid_abandon got activity 1 want 0");
        end
        do_transfer(0, 1'b1, 32'h0000_0040, 16'd0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (!t_done || t_done_cyc != -1 || obs_addr.size() != 0 || t_ready_bad) begin
            errors++; $display("FAIL rstmid_zero got done %0d at %0d bursts %0d want 1 at -1 bursts 0", t_done, t_done_cyc, obs_addr.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rr();
        test_split_rules();
        test_error();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
